// File: rtl/mux_nx1_arb.sv
// N-to-1 registered multiplexer with valid/ready handshaking on every port.
// The channel is chosen by sel (MODE 0) or by a round-robin arbiter (MODE 1).
module mux_nx1_arb #(
   parameter  int WIDTH  = 32,
   parameter  int NUM_IN = 32,
   parameter  int MODE   = 0,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);

   logic             can_accept;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] grant_hi;
   logic [SEL_W-1:0] grant_lo;
   logic             found_hi;
   logic             xfer;
   logic [WIDTH-1:0] xfer_data;
   logic [SEL_W-1:0] xfer_sel;

   assign can_accept = !out_valid || out_ready;

   // Round-robin search split in two halves: the lowest requester above rr_ptr
   // wins; otherwise wrap to the lowest requester at or below rr_ptr.
   always_comb begin : rr_search
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      grant_hi = '0;
      grant_lo = '0;
      found_hi = 1'b0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            if (SEL_W'(i) > rr_ptr) begin
               grant_hi = SEL_W'(i);
               found_hi = 1'b1;
            end else begin
               grant_lo = SEL_W'(i);
            end
         end
      end
      grant = found_hi ? grant_hi : grant_lo;
   end

   // An out-of-range sel matches no channel, so nothing is accepted.
   always_comb begin : ready_gen
      in_ready = '0;
      if (MODE == 0) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) in_ready[i] = can_accept;
         end
      end else if (|in_valid) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (grant == SEL_W'(i)) in_ready[i] = can_accept;
         end
      end
   end

   // At most one ready bit is set, so at most one channel can match here.
   always_comb begin : xfer_mux
      xfer      = 1'b0;
      xfer_data = '0;
      xfer_sel  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            xfer      = 1'b1;
            xfer_data = in_data[i*WIDTH +: WIDTH];
            xfer_sel  = SEL_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         rr_ptr    <= SEL_W'(NUM_IN - 1);
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= xfer_data;
            out_sel   <= xfer_sel;
            if (MODE == 1) rr_ptr <= xfer_sel;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
